// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, Tuse/Tnew classes,
// MDU latency defaults and the per-stage hazard decode helpers.
package mips_defs;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // TUSE_NONE is numerically above every Tnew, so a non-reader never stalls.
   typedef enum logic [1:0] {
      TUSE_0    = 2'd0,
      TUSE_1    = 2'd1,
      TUSE_2    = 2'd2,
      TUSE_NONE = 2'd3
   } tuse_t;

   typedef enum logic [1:0] {
      TNEW_0 = 2'd0,
      TNEW_1 = 2'd1,
      TNEW_2 = 2'd2
   } tnew_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   function automatic logic is_imm_alu(input logic [5:0] op);
      case (op)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI:            return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_shift_imm_fn(input logic [5:0] fn);
      case (fn)
         FN_SLL, FN_SRL, FN_SRA: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // Register-register ALU ops that read both rs and rt.
   function automatic logic is_rr_alu_fn(input logic [5:0] fn);
      case (fn)
         FN_SLLV, FN_SRLV, FN_SRAV,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
         FN_AND, FN_OR, FN_XOR, FN_NOR,
         FN_SLT, FN_SLTU:                     return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv_fn(input logic [5:0] fn);
      case (fn)
         FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic tuse_t tuse_rs(input logic [31:0] ir);
      tuse_t t;
      t = TUSE_NONE;
      case (ir[31:26])
         OP_SPECIAL: begin
            if (ir[5:0] == FN_JR || ir[5:0] == FN_JALR) begin
               t = TUSE_0;
            end else if (is_rr_alu_fn(ir[5:0]) || is_muldiv_fn(ir[5:0]) ||
                         ir[5:0] == FN_MTHI || ir[5:0] == FN_MTLO) begin
               t = TUSE_1;
            end else begin
               t = TUSE_NONE;
            end
         end
         OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: t = TUSE_0;
         default: begin
            if (is_imm_alu(ir[31:26]) || is_load(ir[31:26]) || is_store(ir[31:26])) begin
               t = TUSE_1;
            end else begin
               t = TUSE_NONE;
            end
         end
      endcase
      return t;
   endfunction

   function automatic tuse_t tuse_rt(input logic [31:0] ir);
      tuse_t t;
      t = TUSE_NONE;
      case (ir[31:26])
         OP_SPECIAL: begin
            if (is_shift_imm_fn(ir[5:0]) || is_rr_alu_fn(ir[5:0]) || is_muldiv_fn(ir[5:0])) begin
               t = TUSE_1;
            end else begin
               t = TUSE_NONE;
            end
         end
         OP_BEQ, OP_BNE: t = TUSE_0;
         default: begin
            if (is_store(ir[31:26])) begin
               t = TUSE_2;
            end else begin
               t = TUSE_NONE;
            end
         end
      endcase
      return t;
   endfunction

   function automatic tnew_t tnew_e(input logic [31:0] ir);
      tnew_t t;
      t = TNEW_0;
      case (ir[31:26])
         OP_SPECIAL: begin
            if (is_shift_imm_fn(ir[5:0]) || is_rr_alu_fn(ir[5:0]) ||
                ir[5:0] == FN_MFHI || ir[5:0] == FN_MFLO) begin
               t = TNEW_1;
            end else begin
               t = TNEW_0;
            end
         end
         OP_LUI: t = TNEW_1;
         OP_JAL: t = TNEW_0;
         default: begin
            if (is_load(ir[31:26])) begin
               t = TNEW_2;
            end else if (is_imm_alu(ir[31:26])) begin
               t = TNEW_1;
            end else begin
               t = TNEW_0;
            end
         end
      endcase
      return t;
   endfunction

   function automatic tnew_t tnew_m(input logic [31:0] ir);
      return is_load(ir[31:26]) ? TNEW_1 : TNEW_0;
   endfunction

   function automatic logic is_md_start_op(input logic [31:0] ir);
      return (ir[31:26] == OP_SPECIAL) && is_muldiv_fn(ir[5:0]);
   endfunction

   function automatic logic is_md_div(input logic [31:0] ir);
      return (ir[31:26] == OP_SPECIAL) && (ir[5:0] == FN_DIV || ir[5:0] == FN_DIVU);
   endfunction

   // Any D-stage instruction that touches HI/LO or the MDU itself.
   function automatic logic is_md_user(input logic [31:0] ir);
      logic hilo_s;
      hilo_s = (ir[5:0] == FN_MFHI) || (ir[5:0] == FN_MTHI) ||
               (ir[5:0] == FN_MFLO) || (ir[5:0] == FN_MTLO);
      return (ir[31:26] == OP_SPECIAL) && (is_muldiv_fn(ir[5:0]) || hilo_s);
   endfunction

   function automatic logic src_hazard(input logic [4:0] src, input tuse_t tuse,
                                       input logic [4:0] a3, input logic we,
                                       input tnew_t tnew);
      return (src != 5'd0) && we && (a3 == src) && (tuse != TUSE_NONE) &&
             (2'(tuse) < 2'(tnew));
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
// MDU occupancy tracker: IDLE/BUSY state plus a down-counter that holds
// md_busy high for exactly the unit's latency after each start pulse.
module md_busy_fsm
   import mips_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   md_state_t  state_r;
   logic [3:0] cnt_r;
   logic       busy_r;

   // State, counter and busy flag advance together so md_busy is a flop output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= MD_IDLE;
         cnt_r   <= 4'd0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            MD_IDLE: begin
               if (md_start) begin
                  state_r <= MD_BUSY;
                  cnt_r   <= md_is_div ? DIV_LOAD : MULT_LOAD;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= MD_IDLE;
                  cnt_r   <= 4'd0;
                  busy_r  <= 1'b0;
               end
            end
            MD_BUSY: begin
               if (cnt_r == 4'd0) begin
                  state_r <= MD_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r   <= cnt_r - 4'd1;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= MD_IDLE;
               cnt_r   <= 4'd0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign md_busy = busy_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall controller: Tuse/Tnew data hazards against E and M, plus
// MDU start sequencing and HI/LO interlock; drives PC/IF-ID/ID-EX controls.
module hazard_stall_ctrl
   import mips_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] IR_M,
   input  logic [4:0]  E_A3,
   input  logic [4:0]  M_A3,
   input  logic        GRFWE_E,
   input  logic        GRFWE_M,
   output logic        stall,
   output logic        pc_en,
   output logic        d_en,
   output logic        e_clr,
   output logic        md_start,
   output logic        md_is_div,
   output logic        md_busy
);

   logic [4:0] rs_s;
   logic [4:0] rt_s;
   tuse_t      tuse_rs_s;
   tuse_t      tuse_rt_s;
   tnew_t      tnew_e_s;
   tnew_t      tnew_m_s;
   logic       data_stall_s;
   logic       md_start_s;
   logic       md_is_div_s;
   logic       md_busy_s;
   logic       md_stall_s;
   logic       stall_s;

   // Data hazard: a source is stalled only when forwarding cannot deliver in time.
   always_comb begin
      rs_s         = IR_D[25:21];
      rt_s         = IR_D[20:16];
      tuse_rs_s    = tuse_rs(IR_D);
      tuse_rt_s    = tuse_rt(IR_D);
      tnew_e_s     = tnew_e(IR_E);
      tnew_m_s     = tnew_m(IR_M);
      data_stall_s = src_hazard(rs_s, tuse_rs_s, E_A3, GRFWE_E, tnew_e_s) |
                     src_hazard(rt_s, tuse_rt_s, E_A3, GRFWE_E, tnew_e_s) |
                     src_hazard(rs_s, tuse_rs_s, M_A3, GRFWE_M, tnew_m_s) |
                     src_hazard(rt_s, tuse_rt_s, M_A3, GRFWE_M, tnew_m_s);
   end

   // MDU start and HI/LO interlock; a stall bubbles E so a start never repeats.
   always_comb begin
      md_start_s  = ~reset & is_md_start_op(IR_E);
      md_is_div_s = is_md_div(IR_E);
      md_stall_s  = is_md_user(IR_D) & (md_start_s | md_busy_s);
      stall_s     = data_stall_s | md_stall_s;
   end

   md_busy_fsm #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_fsm (
      .clk       (clk),
      .reset     (reset),
      .md_start  (md_start_s),
      .md_is_div (md_is_div_s),
      .md_busy   (md_busy_s)
   );

   assign stall     = stall_s;
   assign pc_en     = ~stall_s;
   assign d_en      = ~stall_s;
   assign e_clr     = stall_s;
   assign md_start  = md_start_s;
   assign md_is_div = md_is_div_s;
   assign md_busy   = md_busy_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed plus randomized-pipeline bench for hazard_stall_ctrl, checked against
// an instruction-table reference model.
module tb_hazard_stall_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR_D, IR_E, IR_M;
   logic [4:0]  E_A3, M_A3;
   logic        GRFWE_E, GRFWE_M;
   logic        stall, pc_en, d_en, e_clr, md_start, md_is_div, md_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
      .E_A3(E_A3), .M_A3(M_A3), .GRFWE_E(GRFWE_E), .GRFWE_M(GRFWE_M),
      .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
      .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy)
   );

   // rs/rt: cycle the operand is needed (9 = not read); tn: cycles until result
   // exists when in E; md: 0 none, 1 mult, 2 div, 3 hi/lo move; dst: 0 none, 1 rd, 2 rt, 3 $31
   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int rs; int rt; int tn; int md; int dst;
   } ent_t;

   ent_t tbl[$];
   int   md_left = 0;

   function automatic void add(input logic [5:0] op, input logic [5:0] fn, input int rs,
                               input int rt, input int tn, input int md, input int dst);
      ent_t e;
      e.op = op; e.fn = fn; e.rs = rs; e.rt = rt; e.tn = tn; e.md = md; e.dst = dst;
      tbl.push_back(e);
   endfunction

   function automatic void build_table();
      logic [5:0] fns[13];
      fns = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
      add(6'h00, 6'h00, 9, 1, 1, 0, 1); add(6'h00, 6'h02, 9, 1, 1, 0, 1); add(6'h00, 6'h03, 9, 1, 1, 0, 1);
      foreach (fns[i]) add(6'h00, fns[i], 1, 1, 1, 0, 1);
      add(6'h00, 6'h08, 0, 9, 0, 0, 0); add(6'h00, 6'h09, 0, 9, 0, 0, 1);
      add(6'h00, 6'h10, 9, 9, 1, 3, 1); add(6'h00, 6'h12, 9, 9, 1, 3, 1);
      add(6'h00, 6'h11, 1, 9, 0, 3, 0); add(6'h00, 6'h13, 1, 9, 0, 3, 0);
      add(6'h00, 6'h18, 1, 1, 0, 1, 0); add(6'h00, 6'h19, 1, 1, 0, 1, 0);
      add(6'h00, 6'h1A, 1, 1, 0, 2, 0); add(6'h00, 6'h1B, 1, 1, 0, 2, 0);
      add(6'h01, 6'h00, 0, 9, 0, 0, 0); add(6'h02, 6'h00, 9, 9, 0, 0, 0);
      add(6'h03, 6'h00, 9, 9, 0, 0, 3);
      add(6'h04, 6'h00, 0, 0, 0, 0, 0); add(6'h05, 6'h00, 0, 0, 0, 0, 0);
      add(6'h06, 6'h00, 0, 9, 0, 0, 0); add(6'h07, 6'h00, 0, 9, 0, 0, 0);
      for (int o = 8; o <= 14; o++) add(6'(o), 6'h00, 1, 9, 1, 0, 2);
      add(6'h0F, 6'h00, 9, 9, 1, 0, 2);
      add(6'h20, 6'h00, 1, 9, 2, 0, 2); add(6'h21, 6'h00, 1, 9, 2, 0, 2);
      add(6'h23, 6'h00, 1, 9, 2, 0, 2); add(6'h24, 6'h00, 1, 9, 2, 0, 2);
      add(6'h25, 6'h00, 1, 9, 2, 0, 2);
      add(6'h28, 6'h00, 1, 2, 0, 0, 0); add(6'h29, 6'h00, 1, 2, 0, 0, 0);
      add(6'h2B, 6'h00, 1, 2, 0, 0, 0);
   endfunction

   function automatic ent_t lookup(input logic [31:0] ir);
      ent_t r;
      bit   found;
      r.op = ir[31:26]; r.fn = ir[5:0]; r.rs = 9; r.rt = 9; r.tn = 0; r.md = 0; r.dst = 0;
      found = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (!found && tbl[i].op == ir[31:26] && (ir[31:26] != 6'h00 || tbl[i].fn == ir[5:0])) begin
            r = tbl[i];
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [4:0] dest_of(input logic [31:0] ir);
      ent_t e;
      e = lookup(ir);
      case (e.dst)
         1:       return ir[15:11];
         2:       return ir[20:16];
         3:       return 5'd31;
         default: return 5'd0;
      endcase
   endfunction

   function automatic bit model_data_stall();
      ent_t d, e, m;
      int   src[2];
      int   use_t[2];
      int   tnew_e, tnew_m;
      bit   r;
      d = lookup(IR_D); e = lookup(IR_E); m = lookup(IR_M);
      tnew_e = e.tn;
      tnew_m = (m.tn > 0) ? m.tn - 1 : 0;
      src[0] = int'(IR_D[25:21]); src[1] = int'(IR_D[20:16]);
      use_t[0] = d.rs; use_t[1] = d.rt;
      r = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (src[s] != 0) begin
            if (GRFWE_E && int'(E_A3) == src[s] && use_t[s] < tnew_e) r = 1'b1;
            if (GRFWE_M && int'(M_A3) == src[s] && use_t[s] < tnew_m) r = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic bit model_start();
      ent_t e;
      e = lookup(IR_E);
      return !reset && (e.md == 1 || e.md == 2);
   endfunction

   function automatic bit model_stall();
      ent_t d;
      d = lookup(IR_D);
      return model_data_stall() || (d.md != 0 && (model_start() || md_left > 0));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit   st;
      ent_t e;
      st = model_stall();
      e  = lookup(IR_E);
      chk("stall", 32'(stall), 32'(st));
      chk("pc_en", 32'(pc_en), 32'(!st));
      chk("d_en", 32'(d_en), 32'(!st));
      chk("e_clr", 32'(e_clr), 32'(st));
      chk("md_start", 32'(md_start), 32'(model_start()));
      chk("md_is_div", 32'(md_is_div), 32'(e.md == 2));
      chk("md_busy", 32'(md_busy), 32'(md_left > 0));
      chk("start_while_busy", 32'(md_start && md_busy), 32'd0);
   endtask

   task automatic apply(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                        input logic [4:0] ea3, input logic [4:0] ma3,
                        input logic we, input logic wm, input logic rst);
      @(negedge clk);
      IR_D = d; IR_E = e; IR_M = m; E_A3 = ea3; M_A3 = ma3;
      GRFWE_E = we; GRFWE_M = wm; reset = rst;
      #1;
      check_all();
   endtask

   task automatic tick();
      bit   st;
      ent_t e;
      @(posedge clk);
      st = model_start();
      e  = lookup(IR_E);
      if (reset) md_left = 0;
      else if (md_left > 0) md_left--;
      else if (st) md_left = (e.md == 2) ? 10 : 5;
   endtask

   function automatic logic [31:0] rand_instr();
      ent_t        e;
      logic [31:0] ir;
      e  = tbl[$urandom_range(0, tbl.size() - 1)];
      ir = {e.op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      if (e.op == 6'h00) ir = {e.op, ir[25:16], 5'($urandom_range(0, 3)), 5'd0, e.fn};
      return ir;
   endfunction

   initial begin
      logic [31:0] d_ir, e_ir, m_ir;
      int          nstall;
      bit          st, rst;
      build_table();
      reset = 1'b1; IR_D = NOP; IR_E = NOP; IR_M = NOP;
      E_A3 = 5'd0; M_A3 = 5'd0; GRFWE_E = 1'b0; GRFWE_M = 1'b0;
      tick();

      // reset state
      apply(NOP, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      apply(NOP, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd1);
      chk("rst_busy", 32'(md_busy), 32'd0);
      tick();

      // load then ALU
      apply(32'h00231021, 32'h8C010000, NOP, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      chk("ld_alu_stall", 32'(stall), 32'd1);
      chk("ld_alu_eclr", 32'(e_clr), 32'd1);
      chk("ld_alu_pcen", 32'(pc_en), 32'd0);
      tick();
      apply(32'h00231021, NOP, 32'h8C010000, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0);
      chk("ld_alu_release", 32'(stall), 32'd0);
      tick();

      // load then branch: two stall cycles
      apply(32'h10200001, 32'h8C010000, NOP, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      chk("ld_br_e", 32'(stall), 32'd1);
      tick();
      apply(32'h10200001, NOP, 32'h8C010000, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0);
      chk("ld_br_m", 32'(stall), 32'd1);
      tick();
      apply(32'h10200001, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("ld_br_w", 32'(stall), 32'd0);
      tick();

      // $0 and no-write never stall
      apply(32'h00001021, 32'h8C000000, NOP, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      chk("zero_reg", 32'(stall), 32'd0);
      tick();
      apply(32'h00231021, 32'h8C010000, NOP, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("no_write", 32'(stall), 32'd0);
      tick();

      // mult then mflo: start cycle plus five busy cycles
      apply(32'h00003012, 32'h00850018, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("mult_start", 32'(md_start), 32'd1);
      chk("mult_isdiv", 32'(md_is_div), 32'd0);
      nstall = int'(stall);
      tick();
      for (int i = 0; i < 5; i++) begin
         apply(32'h00003012, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         chk("mult_busy", 32'(md_busy), 32'd1);
         nstall += int'(stall);
         tick();
      end
      apply(32'h00003012, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("mult_done", 32'(md_busy), 32'd0);
      chk("mflo_stall_cycles", 32'(nstall), 32'd6);
      tick();

      // div with an unrelated addu in D
      apply(32'h00231021, 32'h0085001A, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("div_isdiv", 32'(md_is_div), 32'd1);
      tick();
      nstall = 0;
      for (int i = 0; i < 12; i++) begin
         apply(32'h00231021, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         nstall += int'(md_busy);
         chk("div_addu_stall", 32'(stall), 32'd0);
         tick();
      end
      chk("div_busy_cycles", 32'(nstall), 32'd10);

      // reset on busy cycle 4 abandons the divide
      apply(NOP, 32'h0085001A, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(NOP, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      apply(NOP, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_busy", 32'(md_busy), 32'd1);
      tick();
      apply(32'h00002010, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_idle", 32'(md_busy), 32'd0);
      chk("rst_mfhi", 32'(stall), 32'd0);
      tick();

      // randomized pipeline: D holds and E bubbles whenever the model stalls
      d_ir = NOP; e_ir = NOP; m_ir = NOP;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         apply(d_ir, e_ir, m_ir, dest_of(e_ir), dest_of(m_ir),
               (dest_of(e_ir) != 5'd0) && ($urandom_range(0, 7) != 0),
               dest_of(m_ir) != 5'd0, rst);
         st = model_stall();
         tick();
         if (rst) begin
            d_ir = NOP; e_ir = NOP; m_ir = NOP;
         end else if (st) begin
            m_ir = e_ir; e_ir = NOP;
         end else begin
            m_ir = e_ir; e_ir = d_ir; d_ir = rand_instr();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
